// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out symbol serializer with a one-word
// holding buffer so back-to-back symbols leave the block with no idle gap.
// The serial outputs are registered copies of the next shifter state, so they
// never depend combinationally on data_in.
module piso_serializer #(
    parameter int unsigned WIDTH     = 10,
    parameter bit          LSB_FIRST = 1'b0,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_start
);

    localparam int unsigned      CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q,      state_d;
    logic [WIDTH-1:0] sh_q,         sh_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] hold_q,       hold_d;
    logic             hold_full_q,  hold_full_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             word_start_q, word_start_d;

    logic shifter_free;
    logic take;

    // Shifter can accept a new word on this edge: idle, or emitting its last bit
    assign shifter_free = (state_q == IDLE) || (cnt_q == LAST_CNT);

    // Handshake completes whenever the holding register is empty
    assign take = in_valid && !hold_full_q;

    assign in_ready     = ~hold_full_q;
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign word_start   = word_start_q;

    // State register; reset aborts the current word and drops any held word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            sh_q           <= '0;
            cnt_q          <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            serial_out_q   <= IDLE_BIT;
            serial_valid_q <= 1'b0;
            word_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_q           <= sh_d;
            cnt_q          <= cnt_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            word_start_q   <= word_start_d;
        end
    end

    // Next-state: reload from hold, direct load, hold load, shift, or end of word
    always_comb begin
        state_d        = state_q;
        sh_d           = sh_q;
        cnt_d          = cnt_q;
        hold_d         = hold_q;
        hold_full_d    = hold_full_q;
        serial_out_d   = IDLE_BIT;
        serial_valid_d = 1'b0;
        word_start_d   = 1'b0;

        if (shifter_free) begin
            if (hold_full_q) begin
                // Held word takes priority; in_ready is low so no transfer now
                sh_d        = hold_q;
                cnt_d       = '0;
                hold_full_d = 1'b0;
                state_d     = SHIFT;
            end else if (take) begin
                sh_d    = data_in;
                cnt_d   = '0;
                state_d = SHIFT;
            end else begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (LSB_FIRST) begin
                sh_d = {1'b0, sh_q[WIDTH-1:1]};
            end else begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end
            if (take) begin
                hold_d      = data_in;
                hold_full_d = 1'b1;
            end
        end

        // Outputs mirror the state being entered so they appear registered
        if (state_d == SHIFT) begin
            serial_out_d   = LSB_FIRST ? sh_d[0] : sh_d[WIDTH-1];
            serial_valid_d = 1'b1;
            word_start_d   = (cnt_d == '0);
        end
    end

endmodule
